// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the fetch controller and the PC sequencer.
// The master drives control requests; the sequencer drives PC and RAS status.
interface pc_sequencer_if #(
   parameter int AW = 10
);
   logic          stall;
   logic          trap_en;
   logic          ret_en;
   logic          call_en;
   logic          jump_en;
   logic [AW-1:0] jump_addr;
   logic          branch_en;
   logic [AW-1:0] branch_off;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_next;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_overflow;
   logic          ras_underflow;

   modport master (
      output stall, trap_en, ret_en, call_en, jump_en, jump_addr, branch_en, branch_off,
      input  pc, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, trap_en, ret_en, call_en, jump_en, jump_addr, branch_en, branch_off,
      output pc, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// One-cycle redirect latency; stall freezes all state and drops requests (no queuing).
module pc_sequencer #(
   parameter int            AW        = 10,
   parameter int            RAS_DEPTH = 4,
   parameter logic [AW-1:0] RESET_VEC = '0,
   parameter logic [AW-1:0] TRAP_VEC  = 10'h3F0
) (
   input  logic          clk,
   input  logic          reset,
   pc_sequencer_if.slave bus
);
   localparam int            PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int            CW       = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] pc_plus1;
   logic [AW-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_inc;
   logic [PW-1:0] ptr_dec;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic          do_push;
   logic          do_pop;
   logic          ovf_nxt;
   logic          unf_nxt;
   logic          empty_q;
   logic          full_q;
   logic          ovf_q;
   logic          unf_q;

   // ptr_q is the next free slot; when full it also names the oldest entry,
   // so a push while full overwrites the oldest without extra logic.
   always_comb begin
      ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
      ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - PW'(1);
      pc_plus1 = pc_q + AW'(1);
   end

   always_comb begin
      pc_nxt  = pc_plus1;
      cnt_nxt = cnt_q;
      do_push = 1'b0;
      do_pop  = 1'b0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (reset) begin
         pc_nxt  = RESET_VEC;
         cnt_nxt = '0;
      end else if (bus.stall) begin
         pc_nxt = pc_q;
      end else if (bus.trap_en) begin
         pc_nxt = TRAP_VEC;
      end else if (bus.ret_en) begin
         if (cnt_q == '0) begin
            pc_nxt  = TRAP_VEC;
            unf_nxt = 1'b1;
         end else begin
            pc_nxt  = ras_mem[ptr_dec];
            do_pop  = 1'b1;
            cnt_nxt = cnt_q - CW'(1);
         end
      end else if (bus.call_en) begin
         pc_nxt  = bus.jump_addr;
         do_push = 1'b1;
         if (cnt_q == CNT_FULL) begin
            ovf_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt_q + CW'(1);
         end
      end else if (bus.jump_en) begin
         pc_nxt = bus.jump_addr;
      end else if (bus.branch_en) begin
         pc_nxt = pc_q + bus.branch_off;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_VEC;
         ptr_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_nxt;
         cnt_q   <= cnt_nxt;
         empty_q <= (cnt_nxt == '0);
         full_q  <= (cnt_nxt == CNT_FULL);
         ovf_q   <= ovf_nxt;
         unf_q   <= unf_nxt;
         if (do_push) begin
            ptr_q <= ptr_inc;
         end else if (do_pop) begin
            ptr_q <= ptr_dec;
         end
      end
   end

   // Entry storage is never cleared; it is unreachable while the count is zero.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ras_mem[ptr_q] <= pc_plus1;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_next       = pc_nxt;
   assign bus.ras_empty     = empty_q;
   assign bus.ras_full      = full_q;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 10, sets PC/address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, sets return-address-stack entries (>=2).
REQ-003 Parameter RESET_VEC, default 0, is the PC value loaded on reset.
REQ-004 Parameter TRAP_VEC, default 10'h3F0, is the PC value loaded on trap or RAS underflow.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 stall  input  1  freezes the PC, RAS and flag updates.
REQ-008 trap_en  input  1  redirects to TRAP_VEC.
REQ-009 ret_en  input  1  pops the RAS into the PC.
REQ-010 call_en  input  1  pushes pc+1 and jumps to jump_addr.
REQ-011 jump_en  input  1  loads jump_addr.
REQ-012 jump_addr  input  AW  absolute target for jump/call.
REQ-013 branch_en  input  1  applies a relative branch.
REQ-014 branch_off  input  AW  two's-complement offset relative to current pc.
REQ-015 pc  output  AW  registered current PC (instruction-memory address).
REQ-016 pc_next  output  AW  combinational value pc will take at the next edge.
REQ-017 ras_empty  output  1  registered; RAS holds zero entries.
REQ-018 ras_full  output  1  registered; RAS holds RAS_DEPTH entries.
REQ-019 ras_overflow  output  1  registered one-cycle pulse on a call made while full.
REQ-020 ras_underflow  output  1  registered one-cycle pulse on a ret made while empty.

Function
REQ-021 Each edge selects exactly one action by priority: reset > stall > trap > ret > call > jump > branch > increment.
REQ-022 Increment: pc <= pc + 1 modulo 2^AW (3FF wraps to 000 at AW=10).
REQ-023 Branch: pc <= pc + branch_off modulo 2^AW; a negative offset moves backwards.
REQ-024 Jump: pc <= jump_addr; RAS unchanged.
REQ-025 Call: push (pc + 1) mod 2^AW; pc <= jump_addr.
REQ-026 Call while full: overwrite the oldest entry (circular); count stays RAS_DEPTH; pulse ras_overflow.
REQ-027 Ret, RAS not empty: pc <= top entry; count decrements; LIFO order is preserved.
REQ-028 Ret, RAS empty: pc <= TRAP_VEC; count stays 0; pulse ras_underflow.
REQ-029 Trap: pc <= TRAP_VEC; RAS contents and count unchanged.
REQ-030 Stall: pc, RAS and count hold; overflow/underflow flags are 0 that cycle; all other requests are dropped, not queued.
REQ-031 Lower-priority requests asserted in the same cycle as a higher one are ignored (e.g. call+ret pops only).
REQ-032 pc_next equals the value pc is loaded with at the next edge under every condition, including reset (RESET_VEC) and stall (pc).
REQ-033 ras_empty and ras_full reflect the count after the update; they are never both 1.
REQ-034 Latency: a redirect asserted in cycle N is visible on pc in cycle N+1.

Reset
REQ-035 reset sampled high: pc = RESET_VEC, RAS count = 0, ras_empty = 1, ras_full = 0, ras_overflow = 0, ras_underflow = 0.
REQ-036 reset overrides stall and every request in the same cycle, including a mid-call or mid-ret.
REQ-037 RAS entry storage need not be cleared; it is unreadable while count = 0.

Verification
REQ-038 Reset, then 5 idle cycles -> pc 000,001,002,003,004,005; ras_empty = 1.
REQ-039 pc = 3FE, 3 idle cycles -> 3FF, 000, 001 (wrap).
REQ-040 pc = 010, branch_off = 3FC -> pc = 00C; pc = 010, branch_off = 005 -> pc = 015.
REQ-041 Calls at pc 020->100, 100->200, then ret, ret -> pc = 101, then 021; ras_empty = 1.
REQ-042 Five calls with RAS_DEPTH = 4 -> ras_overflow pulses once on the 5th; then four rets return the newest four addresses; a fifth ret -> pc = 3F0 and ras_underflow pulses.
REQ-043 stall held with trap_en, call_en and jump_en all high -> pc and RAS unchanged; same-cycle reset and stall -> pc = RESET_VEC.
